dark_debounce: RTL

//  Downstream consumer of the photoresistor stage's 1-bit 'dark' level; cleans it for robot control logic.
//  - Synchronises the asynchronous level to clk.
//  - Debounces it with a consecutive-sample counter.
//  - Produces a stable level, one-cycle edge pulses and a wrapping count of dark events.

---
 rtl/dark_debounce_pkg.sv | 20 ++
 rtl/dark_debounce_if.sv | 22 ++
 rtl/dark_debounce_sync_2ff.sv | 22 ++
 rtl/dark_debounce.sv | 130 +++++++++++++
 4 files changed

// File: rtl/dark_debounce_pkg.sv
// Shared types and defaults for the dark-level debouncer.
package dark_debounce_pkg;

  typedef enum logic [1:0] {
    LIGHT      = 2'd0,
    PEND_DARK  = 2'd1,
    DARK       = 2'd2,
    PEND_LIGHT = 2'd3
  } db_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int CNT_W_DEF           = 16;
  localparam int EVENT_W_DEF         = 8;

  // Settled-dark and pending-light both still present as dark downstream.
  function automatic logic is_dark(input db_state_t s);
    return (s == DARK) || (s == PEND_LIGHT);
  endfunction

endpackage

// File: rtl/dark_debounce_if.sv
// Level input, controls and cleaned outputs of the dark debouncer.
interface dark_debounce_if #(
  parameter int EVENT_W = 8
);
  logic               dark_raw;
  logic               enable;
  logic               clear_count;
  logic               dark_stable;
  logic               dark_rise;
  logic               dark_fall;
  logic [EVENT_W-1:0] dark_events;

  modport master (
    output dark_raw, enable, clear_count,
    input  dark_stable, dark_rise, dark_fall, dark_events
  );

  modport slave (
    input  dark_raw, enable, clear_count,
    output dark_stable, dark_rise, dark_fall, dark_events
  );
endinterface

// File: rtl/dark_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;
endmodule

// File: rtl/dark_debounce.sv
// Synchronises, debounces and counts the photoresistor dark level.
// state      | meaning
// LIGHT      | settled light, waiting for a dark sample
// PEND_DARK  | counting consecutive dark samples
// DARK       | settled dark, waiting for a light sample
// PEND_LIGHT | counting consecutive light samples
module dark_debounce
  import dark_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int EVENT_W         = EVENT_W_DEF
) (
  input logic            clk,
  input logic            reset,
  dark_debounce_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);

  logic               dark_sync;
  db_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic [EVENT_W-1:0] events_q, events_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.dark_raw),
    .q     (dark_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LIGHT;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      events_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      events_q <= events_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!bus.enable) begin
      // Disabling abandons any pending change and falls back to the settled level.
      cnt_d = '0;
      if (state_q == PEND_DARK)  state_d = LIGHT;
      if (state_q == PEND_LIGHT) state_d = DARK;
    end else begin
      case (state_q)
        LIGHT: begin
          if (dark_sync) begin
            if (SINGLE) begin
              state_d = DARK;
              cnt_d   = '0;
              rise_d  = 1'b1;
            end else begin
              state_d = PEND_DARK;
              cnt_d   = CNT_ONE;
            end
          end
        end
        PEND_DARK: begin
          if (!dark_sync) begin
            state_d = LIGHT;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = DARK;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        DARK: begin
          if (!dark_sync) begin
            if (SINGLE) begin
              state_d = LIGHT;
              cnt_d   = '0;
              fall_d  = 1'b1;
            end else begin
              state_d = PEND_LIGHT;
              cnt_d   = CNT_ONE;
            end
          end
        end
        PEND_LIGHT: begin
          if (dark_sync) begin
            state_d = DARK;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = LIGHT;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = LIGHT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Counts the cycle dark_rise is high; a coincident clear still keeps that event.
  always_comb begin
    events_d = bus.clear_count ? '0 : events_q;
    events_d = events_d + EVENT_W'(rise_q);
  end

  assign bus.dark_stable = is_dark(state_q);
  assign bus.dark_rise   = rise_q;
  assign bus.dark_fall   = fall_q;
  assign bus.dark_events = events_q;
endmodule
